spine_port_arbiter: RTL and testbench

Packet-locking round-robin arbiter for a single spine-router output port. It shares that output among up to NUM_REQ input ports: one leaf or group port per requester bit. The arbiter grants one requester and holds the grant from a packet's first flit to its tail flit. It also applies output-FIFO back-pressure and releases the lock when a stalled owner times out. One instance sits per output port, between the input-port FIFOs and the output-port FIFO, and drives the crossbar select for that output.

---
 rtl/spine_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spine_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spine_port_arbiter.sv
// -----------------------------------------------------------------------------
// spine_port_arbiter
//
// Packet-locking round-robin arbiter for one spine-router output port.
// In IDLE it picks the first requester at or after rr_ptr (wrapping modulo
// NUM_REQ) and locks onto it. While LOCKED, only the owner is granted, one flit
// per cycle when the output FIFO has room. The lock is released on the tail
// flit transfer, or after MAX_IDLE consecutive cycles in which the owner has
// no flit pending.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   req          per-input-port head-of-FIFO flit pending for this output
//   req_tail     per-input-port "pending flit is the packet tail"
//   out_full     output FIFO full, blocks the transfer this cycle
//   grant        combinational one-hot/zero pop + write strobe
//   sel          registered crossbar select (current / last owner)
//   busy         registered, high while a packet lock is held
//   timeout_err  registered one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module spine_port_arbiter #(
    parameter int NUM_REQ  = 11,
    parameter int SEL_W    = 4,
    parameter int MAX_IDLE = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_tail,
    input  logic               out_full,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         idle_cnt_q, idle_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    logic               win_found_s;
    logic [SEL_W-1:0]   win_idx_s;
    logic [SEL_W-1:0]   scan_s;
    logic               owner_req_s;
    logic               owner_tail_s;
    logic               xfer_s;

    // Successor index modulo NUM_REQ; explicit compare because NUM_REQ need
    // not be a power of two.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        logic [SEL_W-1:0] nxt;
        if (idx == SEL_W'(NUM_REQ - 1)) begin
            nxt = {SEL_W{1'b0}};
        end else begin
            nxt = idx + {{(SEL_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Round-robin search: first requester starting at rr_ptr, wrapping.
    // The scan only visits 0..NUM_REQ-1, so out-of-range indices never win.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {SEL_W{1'b0}};
        scan_s      = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found_s && req[scan_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_s;
            end else begin
                win_found_s = win_found_s;
            end
            scan_s = next_idx(scan_s);
        end
    end

    // Owner view of the request lines and the transfer qualifier.
    always_comb begin
        owner_req_s  = req[owner_q];
        owner_tail_s = req_tail[owner_q];
        xfer_s       = (state_q == ST_LOCKED) && owner_req_s && !out_full;
    end

    // Grant decode: only the owner bit, only on an actual transfer.
    always_comb begin
        grant = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = xfer_s && (owner_q == SEL_W'(i));
        end
    end

    // Next-state logic for the lock FSM and its counters.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    owner_d    = win_idx_s;
                    idle_cnt_d = 8'd0;
                    state_d    = ST_LOCKED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s) begin
                    idle_cnt_d = 8'd0;
                    if (owner_tail_s) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_idx(owner_q);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else if (!owner_req_s) begin
                    // Owner absent: count toward the forced release.
                    if (idle_cnt_q == 8'(MAX_IDLE - 1)) begin
                        state_d       = ST_IDLE;
                        rr_ptr_d      = next_idx(owner_q);
                        idle_cnt_d    = 8'd0;
                        timeout_err_d = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                end else begin
                    // Back-pressure only: hold everything, never a timeout.
                    idle_cnt_d = idle_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= {SEL_W{1'b0}};
            rr_ptr_q      <= {SEL_W{1'b0}};
            idle_cnt_q    <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign sel         = owner_q;
    assign busy        = (state_q == ST_LOCKED);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spine_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spine_port_arbiter
//
// Self-checking bench: a hand-written vector table (single packet plus a
// round-robin sweep), directed multi-cycle sequences (back-pressure, timeout,
// wrap, mid-packet reset) and a randomized run compared cycle by cycle against
// a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_spine_port_arbiter;

    localparam int N        = 11;
    localparam int SW       = 4;
    localparam int MAXI     = 15;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  req_tail;
    logic          out_full;
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          busy;
    logic          timeout_err;

    int n_total;
    int n_pass;

    // Behavioural model state
    bit m_locked;
    int m_owner;
    int m_rr;
    int m_absent;
    bit m_to;

    spine_port_arbiter #(.NUM_REQ(N), .SEL_W(SW), .MAX_IDLE(MAXI)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_tail    (req_tail),
        .out_full    (out_full),
        .grant       (grant),
        .sel         (sel),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  rq;
        logic [N-1:0]  tl;
        logic          full;
        logic [N-1:0]  g;
        logic [SW-1:0] s;
        logic          b;
        logic          t;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: advance one clock given this cycle's inputs.
    task automatic model_step(input logic r, input logic [N-1:0] rq,
                              input logic [N-1:0] tl, input logic f);
        bit found;
        int idx;
        if (r) begin
            m_locked = 0; m_owner = 0; m_rr = 0; m_absent = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (!m_locked) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (!found && rq[idx]) begin
                        found = 1; m_owner = idx; m_locked = 1; m_absent = 0;
                    end
                end
            end else if (rq[m_owner] && !f) begin
                m_absent = 0;
                if (tl[m_owner]) begin
                    m_locked = 0; m_rr = (m_owner + 1) % N;
                end
            end else if (!rq[m_owner]) begin
                m_absent++;
                if (m_absent == MAXI) begin
                    m_locked = 0; m_rr = (m_owner + 1) % N; m_to = 1; m_absent = 0;
                end
            end
        end
    endtask

    // One cycle: drive at negedge, compare against model, advance both.
    task automatic cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] tl,
                         input logic f, output logic obs_to);
        logic [N-1:0] eg;
        reset = r; req = rq; req_tail = tl; out_full = f;
        #1;
        eg = '0;
        if (m_locked && rq[m_owner] && !f) eg[m_owner] = 1'b1;
        chk("grant", 32'(grant), 32'(eg));
        chk("sel", 32'(sel), 32'(m_owner));
        chk("busy", 32'(busy), 32'(m_locked));
        chk("timeout_err", 32'(timeout_err), 32'(m_to));
        obs_to = timeout_err;
        model_step(r, rq, tl, f);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic         o;
        logic [N-1:0] mask;
        logic [31:0]  r32;
        int           to_cnt;
        int           to_at;

        n_total = 0; n_pass = 0;
        reset = 1'b1; req = '0; req_tail = '0; out_full = 1'b0;

        // Single 3-flit packet on port 2, then 1-flit packets on 0/5/10.
        vecs[0]  = '{11'h000, 11'h000, 1'b0, 11'h000, 4'd0,  1'b0, 1'b0};
        vecs[1]  = '{11'h004, 11'h000, 1'b0, 11'h000, 4'd0,  1'b0, 1'b0};
        vecs[2]  = '{11'h004, 11'h000, 1'b0, 11'h004, 4'd2,  1'b1, 1'b0};
        vecs[3]  = '{11'h004, 11'h000, 1'b0, 11'h004, 4'd2,  1'b1, 1'b0};
        vecs[4]  = '{11'h004, 11'h004, 1'b0, 11'h004, 4'd2,  1'b1, 1'b0};
        vecs[5]  = '{11'h000, 11'h000, 1'b0, 11'h000, 4'd2,  1'b0, 1'b0};
        vecs[6]  = '{11'h421, 11'h421, 1'b0, 11'h000, 4'd2,  1'b0, 1'b0};
        vecs[7]  = '{11'h421, 11'h421, 1'b0, 11'h020, 4'd5,  1'b1, 1'b0};
        vecs[8]  = '{11'h421, 11'h421, 1'b0, 11'h000, 4'd5,  1'b0, 1'b0};
        vecs[9]  = '{11'h421, 11'h421, 1'b0, 11'h400, 4'd10, 1'b1, 1'b0};
        vecs[10] = '{11'h421, 11'h421, 1'b0, 11'h000, 4'd10, 1'b0, 1'b0};
        vecs[11] = '{11'h421, 11'h421, 1'b0, 11'h001, 4'd0,  1'b1, 1'b0};
        vecs[12] = '{11'h421, 11'h421, 1'b0, 11'h000, 4'd0,  1'b0, 1'b0};
        vecs[13] = '{11'h421, 11'h421, 1'b0, 11'h020, 4'd5,  1'b1, 1'b0};
        vecs[14] = '{11'h000, 11'h000, 1'b0, 11'h000, 4'd5,  1'b0, 1'b0};

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            req = vecs[i].rq; req_tail = vecs[i].tl; out_full = vecs[i].full;
            #1;
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].g));
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].s));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].b));
            chk($sformatf("vec%0d_tout", i), 32'(timeout_err), 32'(vecs[i].t));
            @(posedge clk);
            @(negedge clk);
        end

        // Resync DUT and model.
        m_locked = 0; m_owner = 0; m_rr = 0; m_absent = 0; m_to = 0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Back-pressure on owner 4: 20 full cycles, tail held during full.
        cycle(1'b0, 11'h010, 11'h000, 1'b0, o);
        cycle(1'b0, 11'h010, 11'h000, 1'b0, o);
        to_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 11'h010, (k > 15) ? 11'h010 : 11'h000, 1'b1, o);
            if (o) to_cnt++;
        end
        chk("bp_no_timeout", 32'(to_cnt), 32'd0);
        chk("bp_still_locked", 32'(busy), 32'd1);
        cycle(1'b0, 11'h010, 11'h000, 1'b0, o);
        cycle(1'b0, 11'h010, 11'h010, 1'b0, o);
        chk("bp_released", 32'(busy), 32'd0);

        // Timeout on owner 7 after its head flit.
        cycle(1'b0, 11'h080, 11'h000, 1'b0, o);
        cycle(1'b0, 11'h080, 11'h000, 1'b0, o);
        to_cnt = 0; to_at = -1;
        for (int k = 0; k < 18; k++) begin
            cycle(1'b0, 11'h000, 11'h000, 1'b0, o);
            if (o) begin to_cnt++; to_at = k; end
        end
        chk("to_pulse_count", 32'(to_cnt), 32'd1);
        chk("to_pulse_cycle", 32'(to_at), 32'd15);
        // Search resumes at 8: among bits 2,7,9 the winner is 9.
        cycle(1'b0, 11'h284, 11'h000, 1'b0, o);
        chk("to_next_winner", 32'(sel), 32'd9);

        // Owner 9 single flit -> rr_ptr 10; then bits 1,3 wrap to owner 1.
        cycle(1'b0, 11'h200, 11'h200, 1'b0, o);
        cycle(1'b0, 11'h00A, 11'h00A, 1'b0, o);
        chk("wrap_winner", 32'(sel), 32'd1);
        cycle(1'b0, 11'h00A, 11'h00A, 1'b0, o);

        // Reset mid-packet on owner 6 at flit 2, then re-arbitrate 6 vs 2.
        cycle(1'b0, 11'h040, 11'h000, 1'b0, o);
        cycle(1'b0, 11'h040, 11'h000, 1'b0, o);
        cycle(1'b1, 11'h040, 11'h000, 1'b0, o);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        cycle(1'b0, 11'h044, 11'h000, 1'b0, o);
        chk("rst_rearb", 32'(sel), 32'd2);
        cycle(1'b0, 11'h044, 11'h004, 1'b0, o);

        // Randomized run against the model.
        mask = '1;
        for (int c = 0; c < 1500; c++) begin
            if (c % 40 == 0) begin
                r32 = $urandom;
                mask = r32[N-1:0];
            end
            r32 = $urandom;
            cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  r32[N-1:0] & mask, r32[N+10:N],
                  ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, o);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
